xge_tx_sched: RTL
=================

XGE_TX_SCHED -- requirements
Module: xge_tx_sched

Interface
REQ-001 Parameter IFG_WORDS, default 2: minimum full-idle XGMII words emitted after every terminate or error word.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 src_valid  in  2  per-source word valid; index 0 = source 0, index 1 = source 1.
REQ-005 src_ready  out  2  per-source accept; a word transfers when valid and ready are both high.
REQ-006 src_sop  in  2  first word of a frame.
REQ-007 src_eop  in  2  last word of a frame.
REQ-008 src_eop_bytes  in  2x3  valid bytes in the eop word; 0 encodes 8, 1..7 literal; ignored when eop is low.
REQ-009 src_data  in  2x64  payload; byte k on bits [8k+7:8k] maps to XGMII lane k.
REQ-010 xgmii_txd  out  64  registered XGMII transmit data.
REQ-011 xgmii_txc  out  8  registered XGMII transmit control, bit k = lane k.
REQ-012 grant  out  2  one-hot owner of the current frame; 0 when no frame is in progress.
REQ-013 underrun  out  1  one-cycle pulse when a granted source drops valid mid-frame.

Function
REQ-014 States: IDLE, PREAMBLE, DATA, TERM, IFG, DRAIN.
REQ-015 Idle word is lanes=07, txc=FF; emitted in IDLE and IFG.
REQ-016 IDLE: a source requests when valid and sop are both high; the arbiter picks one request, sets grant, and moves to PREAMBLE; src_ready is 0 for both sources.
REQ-017 IDLE: a source with valid high and sop low gets ready=1, and its words are discarded.
REQ-018 Arbitration is two-way round-robin: with both requesting, grant goes to the source not granted last; after reset, source 0 wins.
REQ-019 PREAMBLE: emits one word, lane0=FB, lanes1-6=55, lane7=D5, txc=01; moves to DATA.
REQ-020 DATA: src_ready of the granted source = 1, other = 0; each accepted non-eop word appears on txd with txc=00 exactly one cycle later.
REQ-021 Eop with n bytes, n<8: lanes 0..n-1 carry data (txc 0), lane n = FD, lanes above = 07, txc bits n..7 = 1; then IFG.
REQ-022 Eop with n=8: full data word, txc=00, then TERM.
REQ-023 TERM: emits lane0=FD, lanes1-7=07, txc=FF; moves to IFG.
REQ-024 IFG: emits exactly IFG_WORDS idle words, counted by a down-counter, then IDLE; grant clears on entry to IFG.
REQ-025 Underrun: in DATA with the granted valid low, emit FE in all lanes with txc=FF, pulse underrun, and move to DRAIN.
REQ-026 DRAIN: keeps ready=1 for the granted source, emits idle, and discards words until an eop is accepted, then moves to IFG; an eop accepted in the same cycle as DRAIN entry counts.
REQ-027 A source with sop high on a word in DATA is treated as data; no nested frame is started.
REQ-028 A single-word frame (sop and eop together) follows the REQ-021/022 rules directly after PREAMBLE.
REQ-029 src_ready is a function of registered state only; no combinational path from src_valid to src_ready.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, xgmii_txd=0707070707070707, xgmii_txc=FF, src_ready=00, grant=00, underrun=0, round-robin pointer = source 1 last, IFG counter 0.
REQ-031 Reset mid-frame abandons the frame; the first post-reset output is idle, and no terminate is owed.

Structure
REQ-032 A shared package xge_tx_sched_pkg holds the state enum and XGMII character constants: IDLE 07, START FB, TERM FD, ERROR FE, PREAMBLE 55, SFD D5.
REQ-033 Sub-module xge_tx_rr_arb, a 2-way round-robin arbiter with a registered last-grant pointer, is instantiated once.
REQ-034 IFG_WORDS sizes the IFG counter as clog2(IFG_WORDS+1) bits.

Verification
REQ-035 Source 0 sends a 3-word frame, eop_bytes=4 -> preamble word, 2 data words, then a word with lanes0-3 data, lane4=FD, txc=F0, then exactly 2 idle words.
REQ-036 Source 1 sends an eop word with eop_bytes=0 -> full data word txc=00, then FD/07 word txc=FF, then 2 idles.
REQ-037 Both sources request in the same cycle, twice -> source 0 granted first, then source 1; the frames never interleave.
REQ-038 Source 0 drops valid after word 1 -> FE word txc=FF, underrun pulses for 1 cycle, words are drained until eop, then 2 idles.
REQ-039 rst_n is asserted during DATA -> outputs are idle/FF in the same cycle, grant=00, and a fresh frame after release starts with the preamble.
REQ-040 Source 1 presents valid without sop in IDLE -> the words are accepted and discarded, and txd stays idle.

Source files
------------

// File: rtl/xge_tx_sched_pkg.sv
// Shared definitions for the two-source XGMII transmit scheduler:
// FSM state type, XGMII control characters and word-building helpers.
package xge_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_TERM,
        ST_IFG,
        ST_DRAIN
    } state_e;

    localparam logic [7:0] XGMII_IDLE     = 8'h07;
    localparam logic [7:0] XGMII_START    = 8'hFB;
    localparam logic [7:0] XGMII_TERM     = 8'hFD;
    localparam logic [7:0] XGMII_ERROR    = 8'hFE;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SFD      = 8'hD5;

    typedef struct packed {
        logic [63:0] txd;
        logic [7:0]  txc;
    } xgmii_word_t;

    function automatic xgmii_word_t idle_word();
        xgmii_word_t w;
        w.txd = {8{XGMII_IDLE}};
        w.txc = '1;
        return w;
    endfunction

    function automatic xgmii_word_t preamble_word();
        xgmii_word_t w;
        w.txd = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
        w.txc = 8'h01;
        return w;
    endfunction

    function automatic xgmii_word_t term_word();
        xgmii_word_t w;
        w.txd = {{7{XGMII_IDLE}}, XGMII_TERM};
        w.txc = '1;
        return w;
    endfunction

    function automatic xgmii_word_t error_word();
        xgmii_word_t w;
        w.txd = {8{XGMII_ERROR}};
        w.txc = '1;
        return w;
    endfunction

    // nb == 0 means all eight lanes carry data and the terminate goes in a separate word.
    function automatic xgmii_word_t eop_word(input logic [63:0] data, input logic [2:0] nb);
        xgmii_word_t w;
        int unsigned n;
        n = {29'd0, nb};
        for (int unsigned k = 0; k < 8; k++) begin
            if (n == 0 || k < n) begin
                w.txd[8*k +: 8] = data[8*k +: 8];
                w.txc[k]        = 1'b0;
            end else if (k == n) begin
                w.txd[8*k +: 8] = XGMII_TERM;
                w.txc[k]        = 1'b1;
            end else begin
                w.txd[8*k +: 8] = XGMII_IDLE;
                w.txc[k]        = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/xge_tx_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner pointer.
module xge_tx_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (adv_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Pointer resets to "source 1 won last" so source 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/xge_tx_sched.sv
// Two-source XGMII transmit scheduler: arbitrates frames, inserts preamble,
// terminate and inter-frame gap, and flags source underruns.
module xge_tx_sched #(
    parameter int unsigned IFG_WORDS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      src_valid_i,
    output logic [1:0]      src_ready_o,
    input  logic [1:0]      src_sop_i,
    input  logic [1:0]      src_eop_i,
    input  logic [1:0][2:0] src_eop_bytes_i,
    input  logic [1:0][63:0] src_data_i,
    output logic [63:0]     xgmii_txd_o,
    output logic [7:0]      xgmii_txc_o,
    output logic [1:0]      grant_o,
    output logic            underrun_o
);

    import xge_tx_sched_pkg::*;

    localparam int unsigned CNT_W = (IFG_WORDS > 0) ? $clog2(IFG_WORDS + 1) : 1;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       disc_q, disc_d;
    logic [CNT_W-1:0] ifg_cnt_q, ifg_cnt_d;
    logic [63:0]      txd_q, txd_d;
    logic [7:0]       txc_q, txc_d;
    logic             underrun_q, underrun_d;

    logic [1:0]  req;
    logic [1:0]  arb_gnt;
    logic        arb_adv;
    logic        gidx;
    logic        g_valid;
    logic        g_eop;
    logic [2:0]  g_nb;
    logic [63:0] g_data;
    logic        to_ifg;
    xgmii_word_t eop_w;

    assign req = src_valid_i & src_sop_i;

    xge_tx_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .adv_i (arb_adv),
        .gnt_o (arb_gnt)
    );

    assign gidx    = grant_q[1];
    assign g_valid = src_valid_i[gidx];
    assign g_eop   = src_eop_i[gidx];
    assign g_nb    = src_eop_bytes_i[gidx];
    assign g_data  = src_data_i[gidx];
    assign eop_w   = eop_word(g_data, g_nb);

    // Ready decodes registered state only; IDLE discard readiness is a flag
    // captured from the previous cycle's non-sop valid.
    always_comb begin
        src_ready_o = '0;
        case (state_q)
            ST_DATA, ST_DRAIN: src_ready_o = grant_q;
            ST_IDLE:           src_ready_o = disc_q;
            default:           src_ready_o = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        disc_d     = '0;
        ifg_cnt_d  = ifg_cnt_q;
        txd_d      = {8{XGMII_IDLE}};
        txc_d      = '1;
        underrun_d = 1'b0;
        arb_adv    = 1'b0;
        to_ifg     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    grant_d = arb_gnt;
                    arb_adv = 1'b1;
                    state_d = ST_PREAMBLE;
                end else begin
                    disc_d = src_valid_i & ~src_sop_i;
                end
            end
            ST_PREAMBLE: begin
                txd_d   = preamble_word().txd;
                txc_d   = preamble_word().txc;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!g_valid) begin
                    txd_d      = error_word().txd;
                    txc_d      = error_word().txc;
                    underrun_d = 1'b1;
                    state_d    = ST_DRAIN;
                end else if (g_eop) begin
                    txd_d = eop_w.txd;
                    txc_d = eop_w.txc;
                    if (g_nb == 3'd0) begin
                        state_d = ST_TERM;
                    end else begin
                        to_ifg = 1'b1;
                    end
                end else begin
                    txd_d = g_data;
                    txc_d = '0;
                end
            end
            ST_TERM: begin
                txd_d  = term_word().txd;
                txc_d  = term_word().txc;
                to_ifg = 1'b1;
            end
            ST_IFG: begin
                if (ifg_cnt_q <= CNT_W'(1)) begin
                    ifg_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (g_valid && g_eop) begin
                    to_ifg = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_ifg) begin
            grant_d = '0;
            if (IFG_WORDS == 0) begin
                state_d = ST_IDLE;
            end else begin
                state_d   = ST_IFG;
                ifg_cnt_d = CNT_W'(IFG_WORDS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            disc_q     <= '0;
            ifg_cnt_q  <= '0;
            txd_q      <= {8{XGMII_IDLE}};
            txc_q      <= '1;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            disc_q     <= disc_d;
            ifg_cnt_q  <= ifg_cnt_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            underrun_q <= underrun_d;
        end
    end

    assign xgmii_txd_o = txd_q;
    assign xgmii_txc_o = txc_q;
    assign grant_o     = grant_q;
    assign underrun_o  = underrun_q;

endmodule
